// File: rtl/uart_tx_frame.sv
// uart_tx_frame: drains a 4-byte transmit buffer as back-to-back UART frames.
// Waits for the buffer's full flag, sends each byte LSB first, pulses rd after
// each frame and re-arms only once full has dropped.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit, 8E1 frames).
// Without it the frame is 8N1.
// All outputs are registered from the current state, so the line follows the
// state register by one clock (tx falls two edges after full is sampled).
module uart_tx_frame #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       full,
   input  logic [7:0] r_data,
   output logic       rd,
   output logic       tx,
   output logic       busy,
   output logic [1:0] byte_idx,
   output logic       done_tick
);

   localparam int unsigned          BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_ACK,
      S_DRAIN
   } state_t;

   state_t              r_state;
   logic [7:0]          r_shreg;
   logic [BAUD_W-1:0]   r_baud;
   logic [2:0]          r_bit;
`ifdef UART_TX_PARITY_EN
   logic                r_par;
`endif

   logic                w_baud_last;

   assign w_baud_last = (r_baud == BAUD_LAST);

   // Frame sequencer: state, baud/bit counters, shift register and all outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_shreg   <= '0;
         r_baud    <= '0;
         r_bit     <= '0;
`ifdef UART_TX_PARITY_EN
         r_par     <= 1'b0;
`endif
         tx        <= 1'b1;
         rd        <= 1'b0;
         busy      <= 1'b0;
         byte_idx  <= '0;
         done_tick <= 1'b0;
      end else begin
         rd        <= 1'b0;
         done_tick <= 1'b0;
         case (r_state)
            S_IDLE: begin
               tx       <= 1'b1;
               busy     <= 1'b0;
               byte_idx <= '0;
               if (full) begin
                  r_state <= S_LOAD;
               end
            end

            S_LOAD: begin
               tx      <= 1'b1;
               busy    <= 1'b1;
               r_shreg <= r_data;
               r_baud  <= '0;
               r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
               r_par   <= ^r_data;
`endif
               r_state <= S_START;
            end

            S_START: begin
               tx   <= 1'b0;
               busy <= 1'b1;
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

            S_DATA: begin
               tx   <= r_shreg[0];
               busy <= 1'b1;
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_shreg <= {1'b0, r_shreg[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               tx   <= r_par;
               busy <= 1'b1;
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
`endif

            S_STOP: begin
               tx   <= 1'b1;
               busy <= 1'b1;
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_state <= S_ACK;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

            S_ACK: begin
               tx   <= 1'b1;
               busy <= 1'b1;
               rd   <= 1'b1;
               if (byte_idx == 2'd3) begin
                  done_tick <= 1'b1;
                  r_state   <= S_DRAIN;
               end else begin
                  byte_idx <= byte_idx + 2'd1;
                  r_state  <= S_LOAD;
               end
            end

            S_DRAIN: begin
               // hold off until the buffer has cleared full, so a stale burst is never resent
               tx   <= 1'b1;
               busy <= 1'b1;
               if (!full) begin
                  byte_idx <= '0;
                  r_state  <= S_IDLE;
               end
            end

            default: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
